// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives a req/ack instruction memory port and
// hands instructions to decode under a stall handshake. Optional feature macro: FETCH_OOB_TRAP_EN.
module fetch_controller #(
    parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
    parameter logic [31:0] IMEM_LAST = 32'h0100_07FC,
    parameter logic [31:0] TRAP_VEC  = 32'h0100_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        oob_trap
);

`ifdef FETCH_OOB_TRAP_EN
    localparam logic [31:0] OOB_TARGET = TRAP_VEC;
`else
    localparam logic [31:0] OOB_TARGET = IMEM_BASE;
    logic [31:0] unused_trap_vec;
    assign unused_trap_vec = TRAP_VEC;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic        pc_update;
    logic [31:0] pc_cand;
    logic        cand_ovf;
    logic        cand_oob;
    logic [31:0] redirect_pc;
    logic [31:0] seq_pc;
    logic        seq_carry;
    logic        unused_redirect_lsbs;

    assign redirect_pc          = {redirect_addr[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_addr[1:0];
    assign {seq_carry, seq_pc}  = {1'b0, pc_q} + 33'd4;

    // A carry out of pc+4 wrapped past the top of the address space.
    assign cand_oob = cand_ovf || (pc_cand < IMEM_BASE) || (pc_cand > IMEM_LAST);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_update     = 1'b0;
        pc_cand       = pc_q;
        cand_ovf      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = IMEM_BASE;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    // Any data acked this cycle belongs to the abandoned path.
                    pc_update     = 1'b1;
                    pc_cand       = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_update     = 1'b1;
                    pc_cand       = seq_pc;
                    cand_ovf      = seq_carry;
                    state_d       = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (redirect) begin
                    pc_update     = 1'b1;
                    pc_cand       = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase

        if (pc_update) begin
            pc_d = cand_oob ? OOB_TARGET : pc_cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= IMEM_BASE;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_OOB_TRAP_EN
    logic oob_trap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_trap_q <= 1'b0;
        end else begin
            oob_trap_q <= pc_update && cand_oob;
        end
    end

    assign oob_trap = oob_trap_q;
`else
    assign oob_trap = 1'b0;
`endif

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: stimulus pushes expected fetch addresses,
// deliveries and trap pulses; a negedge monitor pops and compares on each DUT event.
module tb_fetch_controller;

    localparam logic [31:0] IMEM_BASE = 32'h0100_0000;
    localparam logic [31:0] IMEM_LAST = 32'h0100_07FC;
    localparam logic [31:0] TRAP_VEC  = 32'h0100_0040;
`ifdef FETCH_OOB_TRAP_EN
    localparam logic [31:0] OOB_TGT = TRAP_VEC;
    localparam bit          TRAP_ON = 1'b1;
`else
    localparam logic [31:0] OOB_TGT = IMEM_BASE;
    localparam bit          TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        oob_trap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } deliv_t;

    deliv_t      exp_deliv[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_trap[$];

    fetch_controller #(
        .IMEM_BASE(IMEM_BASE),
        .IMEM_LAST(IMEM_LAST),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .oob_trap     (oob_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new request address, delivery and trap pulse must match the queue head.
    logic        prev_req   = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr  = 32'd0;

    always @(negedge clk) begin
        if (imem_req === 1'b1 && (!prev_req || imem_addr !== prev_addr)) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] ea;
                ea = exp_addr.pop_front();
                $display("req   addr=%08h expect=%08h", imem_addr, ea);
                check("req_addr", imem_addr, ea);
            end
        end
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (exp_deliv.size() == 0) begin
                check("unexpected_deliver", instr_pc, 32'hFFFF_FFFF);
            end else begin
                deliv_t ed;
                ed = exp_deliv.pop_front();
                $display("deliv pc=%08h instr=%08h expect pc=%08h instr=%08h",
                         instr_pc, instr, ed.pc, ed.data);
                check("deliver_instr", instr, ed.data);
                check("deliver_pc", instr_pc, ed.pc);
            end
        end
        if (oob_trap === 1'b1) begin
            if (exp_trap.size() == 0) begin
                check("unexpected_trap", imem_addr, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] et;
                et = exp_trap.pop_front();
                $display("trap  pc=%08h expect=%08h", imem_addr, et);
                check("trap_pc", imem_addr, et);
            end
        end
        prev_req   = (imem_req === 1'b1);
        prev_valid = (instr_valid === 1'b1);
        prev_addr  = imem_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        #12;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, IMEM_BASE);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_trap", {31'd0, oob_trap}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: first fetch with one wait cycle
        exp_addr.push_back(32'h0100_0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wait_req_held", {31'd0, imem_req}, 32'd1);
        exp_deliv.push_back('{data: 32'h0000_0013, pc: 32'h0100_0000});
        exp_addr.push_back(32'h0100_0004);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        imem_ack = 1'b0;

        // 2: stall holds the delivered instruction for three cycles
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, 32'h0000_0013);
            check("stall_instr_pc", instr_pc, 32'h0100_0000);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("resume_req", {31'd0, imem_req}, 32'd1);

        // 3: redirect collides with ack; data is dropped
        exp_addr.push_back(32'h0100_0100);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1;
        redirect_addr = 32'h0100_0103;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check("drop_valid", {31'd0, instr_valid}, 32'd0);
        exp_deliv.push_back('{data: 32'h0000_0011, pc: 32'h0100_0100});
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0011;
        tick();
        imem_ack = 1'b0;
        // redirect beats stall in DELIVER
        exp_addr.push_back(32'h0100_0180);
        stall = 1'b1;
        redirect = 1'b1;
        redirect_addr = 32'h0100_0180;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        check("deliver_redirect_valid", {31'd0, instr_valid}, 32'd0);

        // 4: sequential fetch off the last word
        exp_addr.push_back(IMEM_LAST);
        redirect = 1'b1;
        redirect_addr = IMEM_LAST;
        tick();
        redirect = 1'b0;
        exp_deliv.push_back('{data: 32'h0000_0022, pc: IMEM_LAST});
        exp_addr.push_back(OOB_TGT);
        if (TRAP_ON) exp_trap.push_back(OOB_TGT);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0022;
        tick();
        imem_ack = 1'b0;
        check("wrap_trap_pulse", {31'd0, oob_trap}, {31'd0, TRAP_ON});
        tick();
        check("wrap_trap_end", {31'd0, oob_trap}, 32'd0);
        check("wrap_addr", imem_addr, OOB_TGT);

        // 5: out-of-window redirects below and above the window
        exp_addr.push_back(32'h0100_0300);
        redirect = 1'b1;
        redirect_addr = 32'h0100_0300;
        tick();
        exp_addr.push_back(OOB_TGT);
        if (TRAP_ON) exp_trap.push_back(OOB_TGT);
        redirect_addr = 32'h00FF_FFFC;
        tick();
        exp_addr.push_back(32'h0100_0300);
        redirect_addr = 32'h0100_0300;
        tick();
        exp_addr.push_back(OOB_TGT);
        if (TRAP_ON) exp_trap.push_back(OOB_TGT);
        redirect_addr = 32'h0200_0000;
        tick();
        redirect = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_addr", imem_addr, OOB_TGT);
        check("start_ignored_req", {31'd0, imem_req}, 32'd1);

        // 6: async reset mid-request
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        check("async_rst_addr", imem_addr, IMEM_BASE);
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h0100_0300;
        tick();
        redirect = 1'b0;
        tick();
        check("idle_req", {31'd0, imem_req}, 32'd0);
        check("idle_addr", imem_addr, IMEM_BASE);
        exp_addr.push_back(IMEM_BASE);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_deliv.push_back('{data: 32'h0000_0033, pc: IMEM_BASE});
        exp_addr.push_back(32'h0100_0004);
        imem_ack = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();

        check("left_addr", exp_addr.size(), 32'd0);
        check("left_deliv", exp_deliv.size(), 32'd0);
        check("left_trap", exp_trap.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
